// File: rtl/gpr_file_pkg.sv
// Shared CPU constants and types for the general-purpose register file.
package gpr_file_pkg;

   localparam int unsigned GPR_ADDR_W = 5;
   localparam int unsigned GPR_DATA_W = 32;

   typedef logic [GPR_ADDR_W-1:0] gpr_addr_t;

   localparam gpr_addr_t REG_ZERO = 5'd0;

endpackage

// File: rtl/gpr_file_scoreboard.sv
// Pending-load scoreboard: one bit per register, set by load issue, cleared by
// writeback, and a combinational stall for decode operands.
module gpr_scoreboard
   import gpr_file_pkg::*;
#(
   parameter int unsigned ADDR_W    = GPR_ADDR_W,
   parameter bit          BYPASS_EN = 1'b1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              gpr_we,
   input  logic [ADDR_W-1:0] gpr_wa,
   input  logic              pend_set,
   input  logic [ADDR_W-1:0] pend_addr,
   input  logic [ADDR_W-1:0] rs_addr,
   input  logic [ADDR_W-1:0] rt_addr,
   input  logic              rs_used,
   input  logic              rt_used,
   output logic              stall
);

   localparam int unsigned NREG = 2 ** ADDR_W;

   logic [NREG-1:0] pend;
   logic            wb_hit_rs;
   logic            wb_hit_rt;
   logic            haz_rs;
   logic            haz_rt;

   // Set is applied after clear so a new load issued on its predecessor's
   // writeback cycle keeps the register pending.
   always_ff @(posedge clk) begin
      if (reset) begin
         pend <= '0;
      end else begin
         if (gpr_we && (gpr_wa != '0))
            pend[gpr_wa] <= 1'b0;
         if (pend_set && (pend_addr != '0))
            pend[pend_addr] <= 1'b1;
      end
   end

   always_comb begin
      wb_hit_rs = BYPASS_EN && gpr_we && (gpr_wa == rs_addr);
      wb_hit_rt = BYPASS_EN && gpr_we && (gpr_wa == rt_addr);
      haz_rs    = rs_used && (rs_addr != '0) && pend[rs_addr] && !wb_hit_rs;
      haz_rt    = rt_used && (rt_addr != '0) && pend[rt_addr] && !wb_hit_rt;
      stall     = haz_rs || haz_rt;
   end

endmodule

// File: rtl/gpr_file.sv
// General-purpose register file: two combinational read ports with optional
// write-first bypass, one writeback port, and a pending-load stall.
module gpr_file
   import gpr_file_pkg::*;
#(
   parameter int unsigned DATA_W    = GPR_DATA_W,
   parameter int unsigned ADDR_W    = GPR_ADDR_W,
   parameter bit          BYPASS_EN = 1'b1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] rs_addr,
   input  logic [ADDR_W-1:0] rt_addr,
   output logic [DATA_W-1:0] rs_data,
   output logic [DATA_W-1:0] rt_data,
   input  logic              gpr_we,
   input  logic [ADDR_W-1:0] gpr_wa,
   input  logic [DATA_W-1:0] gpr_data_in,
   input  logic              pend_set,
   input  logic [ADDR_W-1:0] pend_addr,
   input  logic              rs_used,
   input  logic              rt_used,
   output logic              stall
);

   localparam int unsigned NREG = 2 ** ADDR_W;

   logic [DATA_W-1:0] regs [NREG];
   logic              wr_ok;

   assign wr_ok = gpr_we && (gpr_wa != '0);

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned i = 0; i < NREG; i++)
            regs[i] <= '0;
      end else if (wr_ok) begin
         regs[gpr_wa] <= gpr_data_in;
      end
   end

   always_comb begin
      rs_data = '0;
      rt_data = '0;
      if (rs_addr != '0)
         rs_data = (BYPASS_EN && wr_ok && (gpr_wa == rs_addr)) ? gpr_data_in : regs[rs_addr];
      if (rt_addr != '0)
         rt_data = (BYPASS_EN && wr_ok && (gpr_wa == rt_addr)) ? gpr_data_in : regs[rt_addr];
   end

   gpr_scoreboard #(
      .ADDR_W    (ADDR_W),
      .BYPASS_EN (BYPASS_EN)
   ) u_scoreboard (
      .clk       (clk),
      .reset     (reset),
      .gpr_we    (gpr_we),
      .gpr_wa    (gpr_wa),
      .pend_set  (pend_set),
      .pend_addr (pend_addr),
      .rs_addr   (rs_addr),
      .rt_addr   (rt_addr),
      .rs_used   (rs_used),
      .rt_used   (rt_used),
      .stall     (stall)
   );

endmodule

// File: tb/tb_gpr_file.sv
// Scoreboard bench for gpr_file: one bypassing and one non-bypassing instance
// share the same stimulus; expectations are queued per cycle and checked at negedge.
module tb_gpr_file;

   logic        clk = 1'b0;
   logic        reset;
   logic [4:0]  rs_addr, rt_addr, gpr_wa, pend_addr;
   logic [31:0] gpr_data_in;
   logic        gpr_we, pend_set, rs_used, rt_used;

   logic [31:0] rs_data_b, rt_data_b, rs_data_n, rt_data_n;
   logic        stall_b, stall_n;

   always #5 clk = ~clk;

   gpr_file #(.DATA_W(32), .ADDR_W(5), .BYPASS_EN(1'b1)) u_byp (
      .clk(clk), .reset(reset), .rs_addr(rs_addr), .rt_addr(rt_addr),
      .rs_data(rs_data_b), .rt_data(rt_data_b), .gpr_we(gpr_we), .gpr_wa(gpr_wa),
      .gpr_data_in(gpr_data_in), .pend_set(pend_set), .pend_addr(pend_addr),
      .rs_used(rs_used), .rt_used(rt_used), .stall(stall_b)
   );

   gpr_file #(.DATA_W(32), .ADDR_W(5), .BYPASS_EN(1'b0)) u_nob (
      .clk(clk), .reset(reset), .rs_addr(rs_addr), .rt_addr(rt_addr),
      .rs_data(rs_data_n), .rt_data(rt_data_n), .gpr_we(gpr_we), .gpr_wa(gpr_wa),
      .gpr_data_in(gpr_data_in), .pend_set(pend_set), .pend_addr(pend_addr),
      .rs_used(rs_used), .rt_used(rt_used), .stall(stall_n)
   );

   typedef struct {
      int          cyc;
      string       name;
      bit          byp;   // 1: bypassing instance, 0: non-bypassing
      int          sig;   // 0 rs_data, 1 rt_data, 2 stall
      logic [31:0] exp;
   } exp_t;

   exp_t exp_q[$];
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   bit   done = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: pops every expectation due this cycle and compares.
   always @(negedge clk) begin
      exp_t        e;
      logic [31:0] act;
      while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
         e = exp_q.pop_front();
         case (e.sig)
            0:       act = e.byp ? rs_data_b : rs_data_n;
            1:       act = e.byp ? rt_data_b : rt_data_n;
            default: act = {31'd0, (e.byp ? stall_b : stall_n)};
         endcase
         checks++;
         if (e.cyc != cyc || act !== e.exp) begin
            errors++;
            $display("FAIL %s [%s %s] cyc=%0d/%0d actual=%h required=%h", e.name,
                     e.byp ? "byp" : "nobyp",
                     e.sig == 0 ? "rs_data" : (e.sig == 1 ? "rt_data" : "stall"),
                     cyc, e.cyc, act, e.exp);
         end
      end
   end

   task automatic push(input string name, input bit byp, input int sig, input logic [31:0] v);
      exp_t e;
      e.cyc = cyc; e.name = name; e.byp = byp; e.sig = sig; e.exp = v;
      exp_q.push_back(e);
   endtask

   task automatic expect_all(input string name,
                             input logic [31:0] rs_b, input logic [31:0] rt_b, input logic st_b,
                             input logic [31:0] rs_n, input logic [31:0] rt_n, input logic st_n);
      push(name, 1'b1, 0, rs_b);
      push(name, 1'b1, 1, rt_b);
      push(name, 1'b1, 2, {31'd0, st_b});
      push(name, 1'b0, 0, rs_n);
      push(name, 1'b0, 1, rt_n);
      push(name, 1'b0, 2, {31'd0, st_n});
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      reset = 1'b0; gpr_we = 1'b0; gpr_wa = '0; gpr_data_in = '0;
      pend_set = 1'b0; pend_addr = '0; rs_used = 1'b0; rt_used = 1'b0;
      rs_addr = '0; rt_addr = '0;
   endtask

   initial begin
      idle();
      reset = 1'b1;
      step();
      // Reset then read
      idle(); rs_addr = 5'd5; rt_addr = 5'd31;
      expect_all("reset_read", 0, 0, 0, 0, 0, 0);
      step();
      // Write with same-cycle read: write-first vs committed-only
      gpr_we = 1'b1; gpr_wa = 5'd8; gpr_data_in = 32'hDEADBEEF; rs_addr = 5'd8; rt_addr = 5'd0;
      expect_all("wr_same_cycle", 32'hDEADBEEF, 0, 0, 0, 0, 0);
      step();
      idle(); rs_addr = 5'd8;
      expect_all("wr_next_cycle", 32'hDEADBEEF, 0, 0, 32'hDEADBEEF, 0, 0);
      step();
      // Register 0 write and pend_set are dropped
      gpr_we = 1'b1; gpr_wa = 5'd0; gpr_data_in = 32'hFFFFFFFF;
      pend_set = 1'b1; pend_addr = 5'd0; rs_used = 1'b1; rs_addr = 5'd0;
      expect_all("r0_write_cycle", 0, 0, 0, 0, 0, 0);
      step();
      idle(); rs_used = 1'b1; rs_addr = 5'd0; rt_used = 1'b1; rt_addr = 5'd0;
      expect_all("r0_after", 0, 0, 0, 0, 0, 0);
      step();
      // Load-use hazard on r9
      idle(); pend_set = 1'b1; pend_addr = 5'd9; rt_used = 1'b1; rt_addr = 5'd9;
      expect_all("ld_issue", 0, 0, 0, 0, 0, 0);
      step();
      idle(); rt_used = 1'b1; rt_addr = 5'd9;
      expect_all("ld_use_stall", 0, 0, 1, 0, 0, 1);
      step();
      idle(); rt_used = 1'b0; rt_addr = 5'd9;
      expect_all("ld_unused", 0, 0, 0, 0, 0, 0);
      step();
      idle(); rt_used = 1'b1; rt_addr = 5'd9;
      gpr_we = 1'b1; gpr_wa = 5'd9; gpr_data_in = 32'h12345678;
      expect_all("ld_writeback", 0, 32'h12345678, 0, 0, 0, 1);
      step();
      idle(); rt_used = 1'b1; rt_addr = 5'd9;
      expect_all("ld_cleared", 0, 32'h12345678, 0, 0, 32'h12345678, 0);
      step();
      // Set/clear collision on r3: set wins
      idle(); pend_set = 1'b1; pend_addr = 5'd3;
      gpr_we = 1'b1; gpr_wa = 5'd3; gpr_data_in = 32'hA5A50003;
      step();
      idle(); rs_used = 1'b1; rs_addr = 5'd3;
      expect_all("set_wins", 32'hA5A50003, 0, 1, 32'hA5A50003, 0, 1);
      step();
      // Reset mid-hazard discards pending bits and the concurrent write
      idle(); pend_set = 1'b1; pend_addr = 5'd4;
      step();
      idle(); reset = 1'b1; gpr_we = 1'b1; gpr_wa = 5'd4; gpr_data_in = 32'd7;
      step();
      idle(); rs_used = 1'b1; rs_addr = 5'd4; rt_used = 1'b1; rt_addr = 5'd8;
      expect_all("reset_mid_hazard", 0, 0, 0, 0, 0, 0);
      step();
      // Both ports on the same address, top register boundary
      idle(); gpr_we = 1'b1; gpr_wa = 5'd31; gpr_data_in = 32'h0BADF00D;
      rs_addr = 5'd31; rt_addr = 5'd31;
      expect_all("dual_bypass_r31", 32'h0BADF00D, 32'h0BADF00D, 0, 0, 0, 0);
      step();
      idle(); rs_addr = 5'd31; rt_addr = 5'd31;
      expect_all("r31_committed", 32'h0BADF00D, 32'h0BADF00D, 0, 32'h0BADF00D, 32'h0BADF00D, 0);
      step();
      idle();
      step();
      step();
      done = 1'b1;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Global time bound so the run always terminates.
   initial begin
      #100000;
      if (!done) begin
         $display("FAIL timeout actual=running required=finished");
         $fatal(1);
      end
   end

endmodule
